// File: rtl/comma_align.sv
// comma_align: 10-bit word aligner that sits in front of the PCS sync stage.
// It searches a two-word window for the 7-bit comma, locks the bit offset
// after LOCK_COMMAS consistent commas, and emits aligned code-groups one
// clock after each accepted raw word.
//
// Ports:
//   clk           single clock
//   mr_main_reset asynchronous, active-low reset
//   raw_data      deserializer word, raw_data[9] received first
//   raw_valid     raw_data valid this cycle
//   code_group    aligned code-group, code_group[9] is bit 'a'
//   cg_valid      code_group valid
//   aligned       offset is locked
//   align_offset  current bit offset, 0..9
//   comma_seen    emitted code_group starts with a comma
//   realign_cnt   (only with COMMA_ALIGN_STATS_EN) saturating count of
//                 realigns plus lock losses
//
// Optional feature macro: COMMA_ALIGN_STATS_EN
module comma_align #(
  parameter int WIDTH       = 10,
  parameter int LOCK_COMMAS = 3,
  parameter int MISS_LIMIT  = 2048
) (
  input  logic             clk,
  input  logic             mr_main_reset,
  input  logic [WIDTH-1:0] raw_data,
  input  logic             raw_valid,
  output logic [WIDTH-1:0] code_group,
  output logic             cg_valid,
  output logic             aligned,
  output logic [3:0]       align_offset,
  output logic             comma_seen
`ifdef COMMA_ALIGN_STATS_EN
  ,
  output logic [7:0]       realign_cnt
`endif
);

  localparam int CNT_W  = $clog2(LOCK_COMMAS + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {UNLOCKED, CANDIDATE, LOCKED} state_t;

  state_t              state;
  logic [WIDTH-1:0]    prev_p0;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    recnt;
  logic [3:0]          cand;
  logic [3:0]          pend;
  logic [MISS_W-1:0]   miss;

  logic [2*WIDTH-1:0]  win;
  logic [WIDTH-1:0]    comma_vec;
  logic                found;
  logic [3:0]          k_hit;
  logic                cand_done;
  logic                realign_done;
  logic [3:0]          off_next;

  function automatic logic is_comma(input logic [6:0] s);
    return (s == 7'b0011111) || (s == 7'b1100000);
  endfunction

  // Slice at offset k is win[19-k -: 10]; a right shift keeps the index math
  // free of variable part-selects.
  function automatic logic [WIDTH-1:0] slice_at(input logic [2*WIDTH-1:0] w,
                                                 input logic [3:0] k);
    return WIDTH'(w >> (WIDTH - int'(k)));
  endfunction

  function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] m);
    return (int'(m) >= MISS_LIMIT) ? m : m + MISS_W'(1);
  endfunction

`ifdef COMMA_ALIGN_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign win = {prev_p0, raw_data};

  // Comma search; iterating downward lets the lowest offset overwrite.
  always_comb begin
    found = 1'b0;
    k_hit = 4'd0;
    for (int k = 0; k < WIDTH; k++) begin
      comma_vec[k] = is_comma(7'(win >> (2*WIDTH - 7 - k)));
    end
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (comma_vec[k]) begin
        found = 1'b1;
        k_hit = 4'(k);
      end
    end
  end

  // Offset after this cycle's state update, so the comma that completes a
  // lock or realign is already emitted at its new alignment.
  always_comb begin
    cand_done    = found && (k_hit == cand) && (int'(cnt) + 1 >= LOCK_COMMAS);
    realign_done = found && (k_hit != align_offset) &&
                   (((k_hit == pend) ? int'(recnt) + 1 : 1) >= LOCK_COMMAS);
    off_next     = align_offset;
    case (state)
      UNLOCKED:  if (found && LOCK_COMMAS == 1) off_next = k_hit;
      CANDIDATE: if (cand_done) off_next = cand;
      LOCKED:    if (realign_done) off_next = k_hit;
      default:   off_next = align_offset;
    endcase
  end

  // ---- stage p0 -> output: state update and registered outputs ----
  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state        <= UNLOCKED;
      prev_p0      <= '0;
      cnt          <= '0;
      recnt        <= '0;
      cand         <= 4'd0;
      pend         <= 4'd0;
      miss         <= '0;
      code_group   <= '0;
      cg_valid     <= 1'b0;
      aligned      <= 1'b0;
      align_offset <= 4'd0;
      comma_seen   <= 1'b0;
`ifdef COMMA_ALIGN_STATS_EN
      realign_cnt  <= 8'd0;
`endif
    end else begin
      cg_valid <= raw_valid;
      if (raw_valid) begin
        prev_p0      <= raw_data;
        code_group   <= slice_at(win, off_next);
        comma_seen   <= comma_vec[off_next];
        align_offset <= off_next;
        case (state)
          UNLOCKED: begin
            if (found) begin
              if (LOCK_COMMAS == 1) begin
                state   <= LOCKED;
                aligned <= 1'b1;
                miss    <= '0;
                recnt   <= '0;
              end else begin
                state <= CANDIDATE;
                cand  <= k_hit;
                cnt   <= CNT_W'(1);
              end
            end
          end
          CANDIDATE: begin
            if (found) begin
              if (k_hit != cand) begin
                cand <= k_hit;
                cnt  <= CNT_W'(1);
              end else if (cand_done) begin
                state   <= LOCKED;
                aligned <= 1'b1;
                miss    <= '0;
                recnt   <= '0;
                cnt     <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          LOCKED: begin
            if (found && k_hit == align_offset) begin
              miss  <= '0;
              recnt <= '0;
            end else if (realign_done) begin
              pend  <= k_hit;
              recnt <= '0;
              miss  <= '0;
`ifdef COMMA_ALIGN_STATS_EN
              realign_cnt <= sat_inc8(realign_cnt);
`endif
            end else begin
              // A comma elsewhere still counts as a miss at the locked offset.
              if (found) begin
                if (k_hit == pend) begin
                  recnt <= recnt + CNT_W'(1);
                end else begin
                  pend  <= k_hit;
                  recnt <= CNT_W'(1);
                end
              end
              miss <= miss_inc(miss);
              if (int'(miss) + 1 >= MISS_LIMIT) begin
                state   <= UNLOCKED;
                aligned <= 1'b0;
                cnt     <= '0;
`ifdef COMMA_ALIGN_STATS_EN
                realign_cnt <= sat_inc8(realign_cnt);
`endif
              end
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comma_align.sv
module tb_comma_align;

  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b0110110101;
  localparam logic [9:0] D215 = 10'b1010101010;

  logic       clk = 1'b0;
  logic       mr_main_reset;
  logic [9:0] raw_data;
  logic       raw_valid;
  logic [9:0] code_group;
  logic       cg_valid;
  logic       aligned;
  logic [3:0] align_offset;
  logic       comma_seen;
`ifdef COMMA_ALIGN_STATS_EN
  logic [7:0] realign_cnt;
`endif

  always #5 clk = ~clk;

  comma_align dut (
    .clk          (clk),
    .mr_main_reset(mr_main_reset),
    .raw_data     (raw_data),
    .raw_valid    (raw_valid),
    .code_group   (code_group),
    .cg_valid     (cg_valid),
    .aligned      (aligned),
    .align_offset (align_offset),
    .comma_seen   (comma_seen)
`ifdef COMMA_ALIGN_STATS_EN
    ,
    .realign_cnt  (realign_cnt)
`endif
  );

  // -1 in any field means "not checked on this output cycle".
  typedef struct {
    int cgv;
    int al;
    int off;
    int cg;
    int cs;
  } exp_t;

  exp_t       sbq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] last_cg;
  int         shift;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".cg_valid"}, 32'(cg_valid), e.cgv);
    if (e.al  >= 0) chk({tag, ".aligned"},      32'(aligned),      e.al);
    if (e.off >= 0) chk({tag, ".align_offset"}, 32'(align_offset), e.off);
    if (e.cg  >= 0) chk({tag, ".code_group"},   32'(code_group),   e.cg);
    if (e.cs  >= 0) chk({tag, ".comma_seen"},   32'(comma_seen),   e.cs);
  endtask

  // Drive one code-group delayed by 'shift' bits into the raw word stream;
  // the bits ahead of it belong to the tail of the previous code-group.
  task automatic send(input string tag, input logic [9:0] cg, input int al,
                      input int off, input int cgx, input int cs);
    exp_t e;
    exp_t got;
    raw_data  = 10'({last_cg, cg} >> shift);
    raw_valid = 1'b1;
    last_cg   = cg;
    e = '{cgv: 1, al: al, off: off, cg: cgx, cs: cs};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check_out(tag, got);
  endtask

  task automatic idle(input string tag);
    exp_t e;
    exp_t got;
    raw_data  = 10'($urandom);
    raw_valid = 1'b0;
    e = '{cgv: 0, al: -1, off: -1, cg: -1, cs: -1};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check_out(tag, got);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".code_group"},   32'(code_group),   0);
    chk({tag, ".cg_valid"},     32'(cg_valid),     0);
    chk({tag, ".aligned"},      32'(aligned),      0);
    chk({tag, ".align_offset"}, 32'(align_offset), 0);
    chk({tag, ".comma_seen"},   32'(comma_seen),   0);
`ifdef COMMA_ALIGN_STATS_EN
    chk({tag, ".realign_cnt"},  32'(realign_cnt),  0);
`endif
  endtask

  initial begin
    mr_main_reset = 1'b0;
    raw_valid     = 1'b0;
    raw_data      = '0;
    last_cg       = D162;
    shift         = 3;

    #2;
    check_reset_state("reset");
    @(posedge clk);
    #3 mr_main_reset = 1'b1;
    @(posedge clk);
    #1;

    // Lock at offset 3 with idle cycles interleaved.
    send("lk_k0", K285, 0, 0, -1, -1);
    send("lk_d0", D162, 0, 0, -1, -1);
    idle("lk_idle0");
    send("lk_k1", K285, 0, 0, -1, -1);
    idle("lk_idle1");
    send("lk_d1", D162, 0, 0, -1, -1);
    send("lk_k2", K285, 0, 0, -1, -1);
    send("lk_d2", D162, 1, 3, int'(K285), 1);
    send("lk_k3", K285, 1, 3, int'(D162), 0);
    send("lk_d3", D162, 1, 3, int'(K285), 1);

    // Two commas at offset 7, then one back at 3: offset must stay 3.
    shift = 7;
    send("ra_k0", K285, 1, 3, -1, -1);
    send("ra_d0", D162, 1, 3, -1, -1);
    send("ra_k1", K285, 1, 3, -1, -1);
    send("ra_d1", D162, 1, 3, -1, -1);
    shift = 3;
    send("ra_k2", K285, 1, 3, -1, -1);
    send("ra_d2", D162, 1, 3, int'(K285), 1);

    // Three commas at offset 7: realign while staying aligned.
    shift = 7;
    send("rb_k0", K285, 1, 3, -1, -1);
    send("rb_d0", D162, 1, 3, -1, -1);
    send("rb_k1", K285, 1, 3, -1, -1);
    send("rb_d1", D162, 1, 3, -1, -1);
    send("rb_k2", K285, 1, 3, -1, -1);
    send("rb_d2", D162, 1, 7, int'(K285), 1);
    send("rb_k3", K285, 1, 7, int'(D162), 0);
    send("rb_d3", D162, 1, 7, int'(K285), 1);

    // 2047 comma-free words, then a comma at the locked offset.
    for (int i = 0; i < 2046; i++) send("miss_a", D215, 1, 7, -1, -1);
    send("miss_k", K285, 1, 7, -1, -1);
    send("miss_d", D162, 1, 7, int'(K285), 1);

    // 2048 comma-free words: lock drops exactly on the last one.
    for (int i = 1; i <= 2048; i++) begin
      send("drop_a", D215, (i < 2048) ? 1 : 0, 7, -1, -1);
    end
`ifdef COMMA_ALIGN_STATS_EN
    chk("stats_two", 32'(realign_cnt), 2);
`endif

    // Relock at 7 from UNLOCKED (offset held at 7).
    send("rl_k0", K285, 0, 7, -1, -1);
    send("rl_d0", D162, 0, 7, -1, -1);
    send("rl_k1", K285, 0, 7, -1, -1);
    send("rl_d1", D162, 0, 7, -1, -1);
    send("rl_k2", K285, 0, 7, -1, -1);
    send("rl_d2", D162, 1, 7, int'(K285), 1);

    // Asynchronous reset between edges while locked.
    #2;
    mr_main_reset = 1'b0;
    raw_valid     = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    #1;
    check_reset_state("async_rst_hold");
    #3 mr_main_reset = 1'b1;
    @(posedge clk);
    #1;

    // Fresh lock needs three new commas; offset reads 0 until then.
    send("fr_k0", K285, 0, 0, -1, -1);
    send("fr_d0", D162, 0, 0, -1, -1);
    send("fr_k1", K285, 0, 0, -1, -1);
    send("fr_d1", D162, 0, 0, -1, -1);
    send("fr_k2", K285, 0, 0, -1, -1);
    send("fr_d2", D162, 1, 7, int'(K285), 1);
    send("fr_k3", K285, 1, 7, int'(D162), 0);
    send("fr_d3", D162, 1, 7, int'(K285), 1);

`ifdef COMMA_ALIGN_STATS_EN
    // Alternate 3/7 realigns until the counter saturates.
    for (int r = 0; r < 260; r++) begin
      shift = (shift == 7) ? 3 : 7;
      send("sat_k", K285, 1, -1, -1, -1);
      send("sat_d", D162, 1, -1, -1, -1);
      send("sat_k", K285, 1, -1, -1, -1);
      send("sat_d", D162, 1, -1, -1, -1);
      send("sat_k", K285, 1, -1, -1, -1);
      send("sat_d", D162, 1, shift, int'(K285), 1);
    end
    chk("stats_sat", 32'(realign_cnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
